systolic_skew_feeder: RTL and testbench

- Upstream feeder for the MAC systolic array. Accepts one unskewed row vector (horizontal operands) and one unskewed column vector (vertical operands) per cycle through a valid/ready handshake.
- Drives the array's horizontal_input and vertical_input buses with the diagonal skew the array needs: lane k is delayed k cycles relative to lane 0.
- Frames each tile of operand vectors, flushes the skew pipeline with zeros after the last vector, and signals tile completion.

---
 rtl/systolic_skew_feeder.sv | 161 ++++++++++++++++
 tb/tb_systolic_skew_feeder.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_skew_feeder.sv
// Skews row/column operand vectors diagonally for the MAC systolic array, frames tiles and flushes with zeros.
// Optional build macro SKEW_FEEDER_BUBBLE_CNT_EN adds a saturating bubble_cnt output.
module systolic_skew_feeder #(
    parameter int ARR_SIZE      = 4,
    parameter int HORIZONTAL_BW = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              i_mode,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic                              in_last,
    input  logic [HORIZONTAL_BW*ARR_SIZE-1:0] in_h,
    input  logic [HORIZONTAL_BW*ARR_SIZE-1:0] in_v,
    output logic [HORIZONTAL_BW*ARR_SIZE-1:0] horizontal_input,
    output logic [HORIZONTAL_BW*ARR_SIZE-1:0] vertical_input,
    output logic                              o_mode,
    output logic                              feed_active,
`ifdef SKEW_FEEDER_BUBBLE_CNT_EN
    output logic [15:0]                       bubble_cnt,
`endif
    output logic                              tile_done
);

    localparam int CNT_W = (ARR_SIZE > 1) ? $clog2(ARR_SIZE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ARR_SIZE - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t                            r_state;
    state_t                            w_state_nxt;
    logic [CNT_W-1:0]                  r_drain_cnt;
    logic                              r_mode;
    logic                              w_accept;
    logic [HORIZONTAL_BW*ARR_SIZE-1:0] w_h_in;
    logic [HORIZONTAL_BW*ARR_SIZE-1:0] w_v_in;

    assign w_accept = in_valid && in_ready;
    // Non-accepting cycles push zero bubbles so the array never sees stale operands.
    assign w_h_in   = w_accept ? in_h : '0;
    assign w_v_in   = w_accept ? in_v : '0;
    assign o_mode   = r_mode;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = in_last ? ST_DRAIN : ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (w_accept && in_last) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (r_drain_cnt == CNT_LAST) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        in_ready    = 1'b0;
        feed_active = 1'b0;
        tile_done   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
            end
            ST_LOAD: begin
                in_ready    = 1'b1;
                feed_active = 1'b1;
            end
            ST_DRAIN: begin
                feed_active = 1'b1;
                tile_done   = (r_drain_cnt == CNT_LAST);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_drain_cnt <= '0;
        end else if (r_state == ST_DRAIN) begin
            r_drain_cnt <= r_drain_cnt + CNT_ONE;
        end else begin
            r_drain_cnt <= '0;
        end
    end

    // Mode is captured only on the accept that opens a tile and held across IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mode <= 1'b0;
        end else if (r_state == ST_IDLE && w_accept) begin
            r_mode <= i_mode;
        end
    end

    for (genvar k = 0; k < ARR_SIZE; k++) begin : g_lane
        logic [HORIZONTAL_BW-1:0] r_h_chain [0:k];
        logic [HORIZONTAL_BW-1:0] r_v_chain [0:k];

        // NOTE: the skew chains are reset explicitly so a mid-tile reset leaves only zeros on the buses.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                for (int j = 0; j <= k; j++) begin
                    r_h_chain[j] <= '0;
                    r_v_chain[j] <= '0;
                end
            end else begin
                r_h_chain[0] <= w_h_in[k*HORIZONTAL_BW +: HORIZONTAL_BW];
                r_v_chain[0] <= w_v_in[k*HORIZONTAL_BW +: HORIZONTAL_BW];
                for (int j = 1; j <= k; j++) begin
                    r_h_chain[j] <= r_h_chain[j-1];
                    r_v_chain[j] <= r_v_chain[j-1];
                end
            end
        end

        assign horizontal_input[k*HORIZONTAL_BW +: HORIZONTAL_BW] = r_h_chain[k];
        assign vertical_input[k*HORIZONTAL_BW +: HORIZONTAL_BW]   = r_v_chain[k];
    end

`ifdef SKEW_FEEDER_BUBBLE_CNT_EN
    logic [15:0] r_bubble_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bubble_cnt <= '0;
        end else if (r_state == ST_IDLE && w_accept) begin
            r_bubble_cnt <= '0;
        end else if (r_state == ST_LOAD && !in_valid && r_bubble_cnt != 16'hFFFF) begin
            r_bubble_cnt <= r_bubble_cnt + 16'd1;
        end
    end

    assign bubble_cnt = r_bubble_cnt;
`endif

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Self-checking bench for systolic_skew_feeder: abstract model of pushes and drain countdown,
// randomized traffic, and literal expectations for the directed tile scenarios.
module tb_systolic_skew_feeder;

    localparam int N   = 4;
    localparam int HBW = 16;
    localparam int BUS = N * HBW;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           i_mode = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic           in_last = 1'b0;
    logic [BUS-1:0] in_h = '0;
    logic [BUS-1:0] in_v = '0;
    logic [BUS-1:0] horizontal_input;
    logic [BUS-1:0] vertical_input;
    logic           o_mode;
    logic           feed_active;
    logic           tile_done;
`ifdef SKEW_FEEDER_BUBBLE_CNT_EN
    logic [15:0]    bubble_cnt;
`endif

    systolic_skew_feeder #(.ARR_SIZE(N), .HORIZONTAL_BW(HBW)) dut (
        .clk              (clk),
        .rst              (rst),
        .i_mode           (i_mode),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_last          (in_last),
        .in_h             (in_h),
        .in_v             (in_v),
        .horizontal_input (horizontal_input),
        .vertical_input   (vertical_input),
        .o_mode           (o_mode),
        .feed_active      (feed_active),
`ifdef SKEW_FEEDER_BUBBLE_CNT_EN
        .bubble_cnt       (bubble_cnt),
`endif
        .tile_done        (tile_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    bit cmp_en   = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the vector pushed k edges ago (index 0 = newest) supplies lane k of the bus.
    logic [BUS-1:0] m_h [N];
    logic [BUS-1:0] m_v [N];
    int             m_drain;
    bit             m_load;
    bit             m_mode;
    int             m_bub;

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            m_h[k] = '0;
            m_v[k] = '0;
        end
        m_drain = 0;
        m_load  = 1'b0;
        m_mode  = 1'b0;
        m_bub   = 0;
    endtask

    task automatic model_step();
        bit acc;
        acc = in_valid && (m_drain == 0);
        for (int k = N - 1; k > 0; k--) begin
            m_h[k] = m_h[k-1];
            m_v[k] = m_v[k-1];
        end
        m_h[0] = acc ? in_h : '0;
        m_v[0] = acc ? in_v : '0;
        if (m_drain > 0) begin
            m_drain--;
        end else begin
            if (m_load && !in_valid) m_bub = (m_bub == 65535) ? 65535 : m_bub + 1;
            if (acc) begin
                if (!m_load) begin
                    m_mode = i_mode;
                    m_bub  = 0;
                end
                if (in_last) begin
                    m_drain = N;
                    m_load  = 1'b0;
                end else begin
                    m_load = 1'b1;
                end
            end
        end
    endtask

    function automatic logic [BUS-1:0] skew_of(input bit vert);
        logic [BUS-1:0] r;
        r = '0;
        for (int k = 0; k < N; k++) begin
            r[k*HBW +: HBW] = vert ? m_v[k][k*HBW +: HBW] : m_h[k][k*HBW +: HBW];
        end
        return r;
    endfunction

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) model_reset();
            else      model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                check("h_bus",       128'(horizontal_input), 128'(skew_of(1'b0)));
                check("v_bus",       128'(vertical_input),   128'(skew_of(1'b1)));
                check("in_ready",    128'(in_ready),         128'(m_drain == 0));
                check("feed_active", 128'(feed_active),      128'(m_load || m_drain > 0));
                check("tile_done",   128'(tile_done),        128'(m_drain == 1));
                check("o_mode",      128'(o_mode),           128'(m_mode));
`ifdef SKEW_FEEDER_BUBBLE_CNT_EN
                check("bubble_cnt",  128'(bubble_cnt),       128'(m_bub[15:0]));
`endif
            end
        end
    end

    function automatic logic [BUS-1:0] rand_bus();
        logic [BUS-1:0] r;
        for (int k = 0; k < N; k++) r[k*HBW +: HBW] = HBW'($urandom);
        return r;
    endfunction

    function automatic logic [BUS-1:0] mk_row(input int base, input int r);
        logic [BUS-1:0] v;
        for (int k = 0; k < N; k++) v[k*HBW +: HBW] = HBW'(base + r * 16 + k);
        return v;
    endfunction

    // Inputs change 1 time unit after a rising edge and are taken by the following edge.
    task automatic drive(input bit v, input bit last, input bit mode,
                         input logic [BUS-1:0] h, input logic [BUS-1:0] vv);
        @(posedge clk);
        #1;
        in_valid = v;
        in_last  = last;
        i_mode   = mode;
        in_h     = h;
        in_v     = vv;
    endtask

    task automatic single_tile();
        drive(1'b1, 1'b1, 1'b0, 64'h0004_0003_0002_0001, 64'h0040_0030_0020_0010);
        drive(1'b0, 1'b1, 1'b1, rand_bus(), rand_bus());
        @(negedge clk);
        check("single_t1_h",     128'(horizontal_input), 128'(64'h0000_0000_0000_0001));
        check("single_t1_ready", 128'(in_ready), 128'(1'b0));
        @(negedge clk);
        check("single_t2_h",     128'(horizontal_input), 128'(64'h0000_0000_0002_0000));
        @(negedge clk);
        check("single_t3_h",     128'(horizontal_input), 128'(64'h0000_0003_0000_0000));
        @(negedge clk);
        check("single_t4_h",     128'(horizontal_input), 128'(64'h0004_0000_0000_0000));
        check("single_t4_v",     128'(vertical_input),   128'(64'h0040_0000_0000_0000));
        check("single_t4_done",  128'(tile_done), 128'(1'b1));
        check("model_pin_t4",    128'(skew_of(1'b0)), 128'(64'h0004_0000_0000_0000));
        @(negedge clk);
        check("single_t5_h",     128'(horizontal_input), 128'(64'h0));
        check("single_t5_ready", 128'(in_ready), 128'(1'b1));
        check("single_t5_done",  128'(tile_done), 128'(1'b0));
    endtask

    initial begin
        #1 rst = 1'b0;
        #1 cmp_en = 1'b1;
        check("reset_h", 128'(horizontal_input), 128'(64'h0));
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("idle_ready", 128'(in_ready), 128'(1'b1));
        check("idle_active", 128'(feed_active), 128'(1'b0));
        repeat (10) drive(1'b0, 1'b0, 1'b0, rand_bus(), rand_bus());

        single_tile();
        repeat (2) drive(1'b0, 1'b0, 1'b0, rand_bus(), rand_bus());

        // Four-vector tile; mode is taken from the first accept only.
        drive(1'b1, 1'b0, 1'b1, mk_row(16'h1000, 0), rand_bus());
        drive(1'b1, 1'b0, 1'b0, mk_row(16'h1000, 1), rand_bus());
        drive(1'b1, 1'b0, 1'b0, mk_row(16'h1000, 2), rand_bus());
        drive(1'b1, 1'b1, 1'b0, mk_row(16'h1000, 3), rand_bus());
        drive(1'b0, 1'b0, 1'b1, rand_bus(), rand_bus());
        @(negedge clk);
        check("four_t4_h",    128'(horizontal_input), 128'(64'h1003_1012_1021_1030));
        check("four_t4_mode", 128'(o_mode), 128'(1'b1));
        repeat (3) @(negedge clk);
        check("four_t7_done", 128'(tile_done), 128'(1'b1));
        check("four_t7_mode", 128'(o_mode), 128'(1'b1));
        repeat (2) drive(1'b0, 1'b0, 1'b0, rand_bus(), rand_bus());

        // Bubble in the row-1 slot.
        drive(1'b1, 1'b0, 1'b0, mk_row(16'h2000, 0), rand_bus());
        drive(1'b0, 1'b1, 1'b0, rand_bus(), rand_bus());
        drive(1'b1, 1'b0, 1'b0, mk_row(16'h2000, 2), rand_bus());
        drive(1'b1, 1'b1, 1'b0, mk_row(16'h2000, 3), rand_bus());
        @(negedge clk);
        check("bubble_t3_h", 128'(horizontal_input), 128'(64'h0000_2002_0000_2020));
        repeat (6) drive(1'b0, 1'b0, 1'b0, rand_bus(), rand_bus());
`ifdef SKEW_FEEDER_BUBBLE_CNT_EN
        check("bubble_cnt_lit", 128'(bubble_cnt), 128'(16'd1));
`endif

        // Asynchronous reset two cycles into LOAD.
        drive(1'b1, 1'b0, 1'b0, mk_row(16'h3000, 0), mk_row(16'h3800, 0));
        drive(1'b1, 1'b0, 1'b0, mk_row(16'h3000, 1), mk_row(16'h3800, 1));
        drive(1'b0, 1'b0, 1'b0, rand_bus(), rand_bus());
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("midrst_h",      128'(horizontal_input), 128'(64'h0));
        check("midrst_v",      128'(vertical_input),   128'(64'h0));
        check("midrst_active", 128'(feed_active), 128'(1'b0));
        check("midrst_ready",  128'(in_ready), 128'(1'b1));
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        single_tile();

        // Back-to-back tiles with in_valid held high.
        repeat (80) drive(1'b1, $urandom_range(0, 2) == 0, 1'($urandom), rand_bus(), rand_bus());

        // Random traffic.
        repeat (1500) drive($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0, 1'($urandom),
                            rand_bus(), rand_bus());
        repeat (8) drive(1'b0, 1'b0, 1'b0, rand_bus(), rand_bus());
        @(negedge clk);
        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
